lsq_load_responder: RTL

- Memory-side end of the load-port address/data channel pair: accepts load addresses from a load port, issues them to a fixed-latency synchronous read memory (BRAM), and returns read data in order.
- Sits between the load port's address-out/data-in channels and a BRAM read port.
- Absorbs downstream backpressure with an occupancy-credited result FIFO, so no returning datum is ever dropped.

---
 rtl/lsq_load_responder_if.sv | 47 ++++
 rtl/lsq_load_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lsq_load_responder_if.sv
`default_nettype none
//==============================================================================
// Module   : lsq_load_responder_if
// Brief    : Load-port address/data channels plus the BRAM read port.
// Revision : 1.0 - initial release
//==============================================================================
interface lsq_load_responder_if #(
    parameter int ADDR_TYPE = 32,
    parameter int DATA_TYPE = 32
);
    logic [ADDR_TYPE-1:0] addrIn;
    logic                 addrIn_valid;
    logic                 addrIn_ready;
    logic                 loadEn;
    logic [ADDR_TYPE-1:0] loadAddr;
    logic [DATA_TYPE-1:0] loadData;
    logic [DATA_TYPE-1:0] dataOut;
    logic                 dataOut_valid;
    logic                 dataOut_ready;

    // Responder side.
    modport slave (
        input  addrIn,
        input  addrIn_valid,
        output addrIn_ready,
        output loadEn,
        output loadAddr,
        input  loadData,
        output dataOut,
        output dataOut_valid,
        input  dataOut_ready
    );

    // Load port and memory side.
    modport master (
        output addrIn,
        output addrIn_valid,
        input  addrIn_ready,
        input  loadEn,
        input  loadAddr,
        output loadData,
        input  dataOut,
        input  dataOut_valid,
        output dataOut_ready
    );
endinterface
`default_nettype wire

// File: rtl/lsq_load_responder.sv
`default_nettype none
//==============================================================================
// Module   : lsq_load_responder
// Brief    : Issues load addresses to a fixed-latency BRAM and returns data in
//            order via an occupancy-credited FIFO. Define
//            LSQ_LOAD_RESPONDER_BYPASS_EN for same-cycle return bypass.
// Revision : 1.0 - initial release
//==============================================================================
module lsq_load_responder #(
    parameter int DATA_TYPE  = 32,
    parameter int ADDR_TYPE  = 32,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    lsq_load_responder_if.slave bus
);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH    = c_OCC_W'(FIFO_DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    logic                 r_live;
    logic [c_OCC_W-1:0]   r_occ;
    logic [c_OCC_W-1:0]   r_count;
    logic [LATENCY-1:0]   r_inFlight;
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [DATA_TYPE-1:0] r_mem [FIFO_DEPTH];

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_ret;
    logic                 w_fifoValid;
    logic                 w_outValid;
    logic                 w_pop;
    logic                 w_fifoPop;
    logic                 w_push;
    logic [DATA_TYPE-1:0] w_fifoData;
    logic [DATA_TYPE-1:0] w_outData;
    logic [ADDR_TYPE-1:0] w_addr;
`ifdef LSQ_LOAD_RESPONDER_BYPASS_EN
    logic                 w_bypass;
`endif

    function automatic logic [c_PTR_W-1:0] nextPtr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_ONE;
    endfunction

    // r_live keeps the port closed while reset is held and for the release cycle.
    assign w_ready     = r_live && (r_occ < c_DEPTH);
    assign w_accept    = bus.addrIn_valid && w_ready;
    assign w_addr      = bus.addrIn;
    assign w_ret       = r_inFlight[LATENCY-1];
    assign w_fifoValid = (r_count != '0);
    assign w_fifoData  = w_fifoValid ? r_mem[r_head] : '0;

`ifdef LSQ_LOAD_RESPONDER_BYPASS_EN
    assign w_bypass   = w_ret && !w_fifoValid;
    assign w_outValid = w_fifoValid || w_bypass;
    assign w_outData  = w_bypass ? bus.loadData : w_fifoData;
    assign w_push     = w_ret && !(w_bypass && bus.dataOut_ready);
`else
    assign w_outValid = w_fifoValid;
    assign w_outData  = w_fifoData;
    assign w_push     = w_ret;
`endif

    assign w_pop     = w_outValid && bus.dataOut_ready;
    assign w_fifoPop = w_pop && w_fifoValid;

    assign bus.addrIn_ready  = w_ready;
    assign bus.loadEn        = w_accept;
    assign bus.loadAddr      = w_addr;
    assign bus.dataOut       = w_outData;
    assign bus.dataOut_valid = w_outValid;

    // Credit counter: reads in flight plus FIFO entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
            r_occ  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept && !w_pop) begin
                r_occ <= r_occ + c_OCC_ONE;
            end else if (!w_accept && w_pop) begin
                r_occ <= r_occ - c_OCC_ONE;
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_inFlight <= '0;
                end else begin
                    r_inFlight[0] <= w_accept;
                end
            end
        end else begin : g_latN
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_inFlight <= '0;
                end else begin
                    r_inFlight <= {r_inFlight[LATENCY-2:0], w_accept};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= nextPtr(r_tail);
            end
            if (w_fifoPop) begin
                r_head <= nextPtr(r_head);
            end
            if (w_push && !w_fifoPop) begin
                r_count <= r_count + c_OCC_ONE;
            end else if (!w_push && w_fifoPop) begin
                r_count <= r_count - c_OCC_ONE;
            end
        end
    end

    // Storage is not reset; r_count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= bus.loadData;
        end
    end
endmodule
`default_nettype wire
